// File: rtl/uart_txrx_param_if.sv
// Bundle of user-side and serial-pin signals for the parametrised UART transceiver.
// The master side is user logic or a bench; the slave side is the transceiver itself.
interface uart_txrx_param_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 8
);
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

    logic                 send_data;
    logic [DATA_BITS-1:0] data_in;
    logic                 tx_busy;
    logic                 serial_out;
    logic                 serial_in;
    logic                 rd_en;
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 parity_error;
    logic                 framing_error;
    logic                 overflow;
    logic [OCC_W-1:0]     fifo_count;

    modport master (
        output send_data, data_in, serial_in, rd_en,
        input  tx_busy, serial_out, data_out, data_valid,
               parity_error, framing_error, overflow, fifo_count
    );

    modport slave (
        input  send_data, data_in, serial_in, rd_en,
        output tx_busy, serial_out, data_out, data_valid,
               parity_error, framing_error, overflow, fifo_count
    );
endinterface

// File: rtl/uart_txrx_param.sv
// Full-duplex UART with configurable word length, parity and stop bits, plus an
// RX FIFO that stores per-word parity/framing flags and a sticky overflow flag.
module uart_txrx_param #(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int BAUD        = 115200,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 1,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic             clk,
    input  logic             rst,
    uart_txrx_param_if.slave bus
);
    localparam int CPB     = CLK_FREQ / BAUD;
    localparam int CNT_W   = $clog2(STOP_BITS * CPB + 1);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int OCC_W   = $clog2(FIFO_DEPTH + 1);
    localparam int ENTRY_W = DATA_BITS + 2;

    localparam logic             HAS_PARITY = (PARITY_MODE != 0);
    localparam logic             ODD_PARITY = (PARITY_MODE == 2);
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(CPB / 2 - 1);
    localparam logic [CNT_W-1:0] STOP_LAST  = CNT_W'(STOP_BITS * CPB - 1);
    localparam logic [3:0]       DATA_LAST  = 4'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } txState_e;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
    } rxState_e;

    // ---------------------------------------------------------------- TX
    txState_e             txState_q;
    logic [CNT_W-1:0]     txCnt_q;
    logic [3:0]           txBit_q;
    logic [DATA_BITS-1:0] txShift_q;
    logic                 txParity_q;
    logic                 txSerial_q;
    logic                 txBusy_q;
    logic                 sendPrev_q;
    logic                 sendEdge;

    assign sendEdge = bus.send_data & ~sendPrev_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            txState_q  <= TX_IDLE;
            txCnt_q    <= '0;
            txBit_q    <= '0;
            txShift_q  <= '0;
            txParity_q <= 1'b0;
            txSerial_q <= 1'b1;
            txBusy_q   <= 1'b0;
            sendPrev_q <= 1'b0;
        end else begin
            sendPrev_q <= bus.send_data;
            case (txState_q)
                TX_IDLE: begin
                    if (sendEdge && !txBusy_q) begin
                        txShift_q  <= bus.data_in;
                        txParity_q <= ODD_PARITY ? ~^bus.data_in : ^bus.data_in;
                        txSerial_q <= 1'b0;
                        txBusy_q   <= 1'b1;
                        txCnt_q    <= '0;
                        txState_q  <= TX_START;
                    end
                end
                TX_START: begin
                    if (txCnt_q == BIT_LAST) begin
                        txCnt_q    <= '0;
                        txBit_q    <= '0;
                        txSerial_q <= txShift_q[0];
                        txState_q  <= TX_DATA;
                    end else begin
                        txCnt_q <= txCnt_q + CNT_W'(1);
                    end
                end
                TX_DATA: begin
                    if (txCnt_q == BIT_LAST) begin
                        txCnt_q   <= '0;
                        // Bit 0 of the shifter is always the bit currently on the line.
                        txShift_q <= txShift_q >> 1;
                        if (txBit_q == DATA_LAST) begin
                            if (HAS_PARITY) begin
                                txSerial_q <= txParity_q;
                                txState_q  <= TX_PARITY;
                            end else begin
                                txSerial_q <= 1'b1;
                                txState_q  <= TX_STOP;
                            end
                        end else begin
                            txBit_q    <= txBit_q + 4'd1;
                            txSerial_q <= txShift_q[1];
                        end
                    end else begin
                        txCnt_q <= txCnt_q + CNT_W'(1);
                    end
                end
                TX_PARITY: begin
                    if (txCnt_q == BIT_LAST) begin
                        txCnt_q    <= '0;
                        txSerial_q <= 1'b1;
                        txState_q  <= TX_STOP;
                    end else begin
                        txCnt_q <= txCnt_q + CNT_W'(1);
                    end
                end
                TX_STOP: begin
                    if (txCnt_q == STOP_LAST) begin
                        txCnt_q   <= '0;
                        txBusy_q  <= 1'b0;
                        txState_q <= TX_IDLE;
                    end else begin
                        txCnt_q <= txCnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    txSerial_q <= 1'b1;
                    txBusy_q   <= 1'b0;
                    txState_q  <= TX_IDLE;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------- RX
    rxState_e             rxState_q;
    logic                 rxSync1_q;
    logic                 rxSync2_q;
    logic [CNT_W-1:0]     rxCnt_q;
    logic [3:0]           rxBit_q;
    logic [DATA_BITS-1:0] rxShift_q;
    logic                 rxParErr_q;
    logic                 rxPush_q;
    logic [DATA_BITS-1:0] rxWord_q;
    logic                 rxPe_q;
    logic                 rxFe_q;
    logic                 rxExpParity;

    assign rxExpParity = ODD_PARITY ? ~^rxShift_q : ^rxShift_q;

    // Sampling points sit half a bit after the detected start edge, then every bit time.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rxState_q  <= RX_IDLE;
            rxSync1_q  <= 1'b1;
            rxSync2_q  <= 1'b1;
            rxCnt_q    <= '0;
            rxBit_q    <= '0;
            rxShift_q  <= '0;
            rxParErr_q <= 1'b0;
            rxPush_q   <= 1'b0;
            rxWord_q   <= '0;
            rxPe_q     <= 1'b0;
            rxFe_q     <= 1'b0;
        end else begin
            rxSync1_q <= bus.serial_in;
            rxSync2_q <= rxSync1_q;
            rxPush_q  <= 1'b0;
            case (rxState_q)
                RX_IDLE: begin
                    if (!rxSync2_q) begin
                        rxCnt_q    <= '0;
                        rxParErr_q <= 1'b0;
                        rxState_q  <= RX_START;
                    end
                end
                RX_START: begin
                    if (rxCnt_q == HALF_LAST) begin
                        rxCnt_q   <= '0;
                        rxBit_q   <= '0;
                        rxState_q <= rxSync2_q ? RX_IDLE : RX_DATA;
                    end else begin
                        rxCnt_q <= rxCnt_q + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (rxCnt_q == BIT_LAST) begin
                        rxCnt_q   <= '0;
                        rxShift_q <= {rxSync2_q, rxShift_q[DATA_BITS-1:1]};
                        if (rxBit_q == DATA_LAST) begin
                            rxState_q <= HAS_PARITY ? RX_PARITY : RX_STOP;
                        end else begin
                            rxBit_q <= rxBit_q + 4'd1;
                        end
                    end else begin
                        rxCnt_q <= rxCnt_q + CNT_W'(1);
                    end
                end
                RX_PARITY: begin
                    if (rxCnt_q == BIT_LAST) begin
                        rxCnt_q    <= '0;
                        rxParErr_q <= (rxSync2_q != rxExpParity);
                        rxState_q  <= RX_STOP;
                    end else begin
                        rxCnt_q <= rxCnt_q + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (rxCnt_q == BIT_LAST) begin
                        rxCnt_q   <= '0;
                        rxPush_q  <= 1'b1;
                        rxWord_q  <= rxShift_q;
                        rxPe_q    <= rxParErr_q;
                        rxFe_q    <= ~rxSync2_q;
                        rxState_q <= RX_IDLE;
                    end else begin
                        rxCnt_q <= rxCnt_q + CNT_W'(1);
                    end
                end
                default: rxState_q <= RX_IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------- FIFO
    logic [ENTRY_W-1:0] fifoMem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wrPtr_q;
    logic [PTR_W-1:0]   rdPtr_q;
    logic [OCC_W-1:0]   count_q;
    logic               overflow_q;
    logic               fifoEmpty;
    logic               fifoFull;
    logic               doPop;
    logic               doPush;
    logic [ENTRY_W-1:0] headEntry;

    assign fifoEmpty = (count_q == '0);
    assign fifoFull  = (count_q == OCC_W'(FIFO_DEPTH));
    assign doPop     = bus.rd_en && !fifoEmpty;
    // A simultaneous pop frees the head slot, so a full FIFO can still accept the word.
    assign doPush    = rxPush_q && (!fifoFull || doPop);
    assign headEntry = fifoMem_q[rdPtr_q];

    always_ff @(posedge clk) begin
        if (doPush) begin
            fifoMem_q[wrPtr_q] <= {rxFe_q, rxPe_q, rxWord_q};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + PTR_W'(1);
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + PTR_W'(1);
            end
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + OCC_W'(1);
                2'b01:   count_q <= count_q - OCC_W'(1);
                default: count_q <= count_q;
            endcase
            if (rxPush_q && fifoFull && !doPop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign bus.tx_busy       = txBusy_q;
    assign bus.serial_out    = txSerial_q;
    assign bus.data_valid    = !fifoEmpty;
    assign bus.data_out      = fifoEmpty ? '0 : headEntry[DATA_BITS-1:0];
    assign bus.parity_error  = fifoEmpty ? 1'b0 : headEntry[DATA_BITS];
    assign bus.framing_error = fifoEmpty ? 1'b0 : headEntry[DATA_BITS+1];
    assign bus.overflow      = overflow_q;
    assign bus.fifo_count    = count_q;
endmodule

// File: tb/tb_uart_txrx_param.sv
// Bench for uart_txrx_param: an even-parity instance fed by a bit-banged line and an
// odd-parity, two-stop-bit instance wired in loopback.
module tb_uart_txrx_param;
    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUD     = 100_000;
    localparam int CPB      = 10;
    localparam int DW       = 8;
    localparam int DEPTH    = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic lineE = 1'b1;

    always #5 clk = ~clk;

    uart_txrx_param_if #(.DATA_BITS(DW), .FIFO_DEPTH(DEPTH)) ifE ();
    uart_txrx_param_if #(.DATA_BITS(DW), .FIFO_DEPTH(DEPTH)) ifO ();

    assign ifE.serial_in = lineE;
    assign ifO.serial_in = ifO.serial_out;

    uart_txrx_param #(
        .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(DW),
        .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)
    ) dutE (
        .clk(clk),
        .rst(rst),
        .bus(ifE.slave)
    );

    uart_txrx_param #(
        .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(DW),
        .PARITY_MODE(2), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)
    ) dutO (
        .clk(clk),
        .rst(rst),
        .bus(ifO.slave)
    );

    int vectors = 0;
    int miscompares = 0;

    // Entries are {framing_error, parity_error, data}.
    logic [DW+1:0] sbE[$];
    logic [DW+1:0] sbO[$];

    task automatic sendFrameE(input logic [7:0] d, input logic badPar,
                              input logic badStop, input logic expectPush);
        logic [10:0] bits;
        bits = {~badStop, (^d) ^ badPar, d, 1'b0};
        if (expectPush) sbE.push_back({badStop, badPar, d});
        for (int b = 0; b < 11; b++) begin
            lineE = bits[b];
            repeat (CPB) @(negedge clk);
        end
        lineE = 1'b1;
        repeat (15) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        ifE.send_data = 1'b0; ifE.data_in = '0; ifE.rd_en = 1'b0;
        ifO.send_data = 1'b0; ifO.data_in = '0; ifO.rd_en = 1'b0;
        lineE = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({ifE.serial_out, ifE.tx_busy, ifE.data_valid, ifE.overflow} !== 4'b1000) begin
            miscompares++;
            $display("[TB] FAIL reset_E_flags: got %b expected 1000",
                     {ifE.serial_out, ifE.tx_busy, ifE.data_valid, ifE.overflow});
        end
        vectors++;
        if ({ifO.serial_out, ifO.tx_busy, ifO.data_valid, ifO.overflow} !== 4'b1000) begin
            miscompares++;
            $display("[TB] FAIL reset_O_flags: got %b expected 1000",
                     {ifO.serial_out, ifO.tx_busy, ifO.data_valid, ifO.overflow});
        end
        vectors++;
        if (ifE.fifo_count !== 4'd0 || ifO.fifo_count !== 4'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_count: got %0d/%0d expected 0/0",
                     ifE.fifo_count, ifO.fifo_count);
        end
        vectors++;
        if ({ifE.data_out, ifE.parity_error, ifE.framing_error} !== 10'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_head: got %h expected 000",
                     {ifE.data_out, ifE.parity_error, ifE.framing_error});
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_tx_even();
        logic [7:0] d;
        logic       expBit;
        d = 8'hA5;
        ifE.data_in = d;
        ifE.send_data = 1'b1;
        @(negedge clk);
        for (int b = 0; b < 11; b++) begin
            for (int c = 0; c < CPB; c++) begin
                if (b == 0) expBit = 1'b0;
                else if (b <= 8) expBit = d[b-1];
                else if (b == 9) expBit = ^d;
                else expBit = 1'b1;
                vectors++;
                if (ifE.serial_out !== expBit || ifE.tx_busy !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL tx_bit%0d_cyc%0d: got line=%b busy=%b expected line=%b busy=1",
                             b, c, ifE.serial_out, ifE.tx_busy, expBit);
                end
                if (b == 0 && c == 1) ifE.data_in = 8'h00;
                if (b == 3 && c == 0) ifE.send_data = 1'b0;
                if (b == 3 && c == 2) ifE.send_data = 1'b1;
                @(negedge clk);
            end
        end
        vectors++;
        if (ifE.tx_busy !== 1'b0 || ifE.serial_out !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL tx_end: got busy=%b line=%b expected busy=0 line=1",
                     ifE.tx_busy, ifE.serial_out);
        end
        ifE.send_data = 1'b0;
        repeat (20) @(negedge clk);
        vectors++;
        if (ifE.tx_busy !== 1'b0 || ifE.serial_out !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL tx_no_retrigger: got busy=%b line=%b expected busy=0 line=1",
                     ifE.tx_busy, ifE.serial_out);
        end
    endtask

    task automatic test_loopback_odd();
        logic [DW+1:0] exp;
        int busyCycles;
        int guard;
        busyCycles = 0;
        guard = 0;
        sbO.push_back({2'b00, 8'h3C});
        ifO.data_in = 8'h3C;
        ifO.send_data = 1'b1;
        @(negedge clk);
        ifO.send_data = 1'b0;
        while (ifO.tx_busy === 1'b1 && guard < 300) begin
            busyCycles++;
            guard++;
            @(negedge clk);
        end
        vectors++;
        if (busyCycles != 120) begin
            miscompares++;
            $display("[TB] FAIL loop_busy_len: got %0d expected 120", busyCycles);
        end
        while (sbO.size() > 0) begin
            guard = 0;
            while (ifO.data_valid !== 1'b1 && guard < 200) begin
                guard++;
                @(negedge clk);
            end
            exp = sbO.pop_front();
            vectors++;
            if ({ifO.data_valid, ifO.framing_error, ifO.parity_error, ifO.data_out} !== {1'b1, exp}) begin
                miscompares++;
                $display("[TB] FAIL loop_pop: got %h expected %h",
                         {ifO.data_valid, ifO.framing_error, ifO.parity_error, ifO.data_out}, {1'b1, exp});
            end
            ifO.rd_en = 1'b1;
            @(negedge clk);
            ifO.rd_en = 1'b0;
        end
        vectors++;
        if (ifO.data_valid !== 1'b0 || ifO.fifo_count !== 4'd0) begin
            miscompares++;
            $display("[TB] FAIL loop_drained: got valid=%b count=%0d expected 0/0",
                     ifO.data_valid, ifO.fifo_count);
        end
    endtask

    task automatic test_error_flags();
        logic [DW+1:0] exp;
        int guard;
        sendFrameE(8'h5A, 1'b1, 1'b0, 1'b1);
        sendFrameE(8'h96, 1'b0, 1'b1, 1'b1);
        vectors++;
        if (ifE.fifo_count !== 4'd2) begin
            miscompares++;
            $display("[TB] FAIL err_count: got %0d expected 2", ifE.fifo_count);
        end
        while (sbE.size() > 0) begin
            guard = 0;
            while (ifE.data_valid !== 1'b1 && guard < 200) begin
                guard++;
                @(negedge clk);
            end
            exp = sbE.pop_front();
            vectors++;
            if ({ifE.data_valid, ifE.framing_error, ifE.parity_error, ifE.data_out} !== {1'b1, exp}) begin
                miscompares++;
                $display("[TB] FAIL err_pop: got %h expected %h",
                         {ifE.data_valid, ifE.framing_error, ifE.parity_error, ifE.data_out}, {1'b1, exp});
            end
            ifE.rd_en = 1'b1;
            @(negedge clk);
            ifE.rd_en = 1'b0;
        end
        vectors++;
        if (ifE.data_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL err_drained: got valid=%b expected 0", ifE.data_valid);
        end
    endtask

    task automatic test_overflow();
        logic [DW+1:0] exp;
        int guard;
        for (int i = 0; i < 9; i++) begin
            sendFrameE(8'(i * 37 + 1), 1'b0, 1'b0, i < 8);
        end
        vectors++;
        if (ifE.fifo_count !== 4'd8 || ifE.overflow !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL ovf_state: got count=%0d ovf=%b expected 8/1",
                     ifE.fifo_count, ifE.overflow);
        end
        while (sbE.size() > 0) begin
            guard = 0;
            while (ifE.data_valid !== 1'b1 && guard < 200) begin
                guard++;
                @(negedge clk);
            end
            exp = sbE.pop_front();
            vectors++;
            if ({ifE.data_valid, ifE.framing_error, ifE.parity_error, ifE.data_out} !== {1'b1, exp}) begin
                miscompares++;
                $display("[TB] FAIL ovf_pop: got %h expected %h",
                         {ifE.data_valid, ifE.framing_error, ifE.parity_error, ifE.data_out}, {1'b1, exp});
            end
            ifE.rd_en = 1'b1;
            @(negedge clk);
            ifE.rd_en = 1'b0;
        end
        vectors++;
        if (ifE.data_valid !== 1'b0 || ifE.overflow !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL ovf_after: got valid=%b ovf=%b expected 0/1",
                     ifE.data_valid, ifE.overflow);
        end
    endtask

    task automatic test_reset_mid_and_glitch();
        logic [DW+1:0] exp;
        int guard;
        ifO.data_in = 8'h81;
        ifO.send_data = 1'b1;
        lineE = 1'b0;
        repeat (25) @(negedge clk);
        ifO.send_data = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (ifO.serial_out !== 1'b1 || ifO.tx_busy !== 1'b0 || ifE.overflow !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midrst_abort: got line=%b busy=%b ovf=%b expected 1/0/0",
                     ifO.serial_out, ifO.tx_busy, ifE.overflow);
        end
        lineE = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        repeat (150) @(negedge clk);
        vectors++;
        if (ifE.fifo_count !== 4'd0 || ifO.fifo_count !== 4'd0) begin
            miscompares++;
            $display("[TB] FAIL midrst_nopush: got %0d/%0d expected 0/0",
                     ifE.fifo_count, ifO.fifo_count);
        end
        lineE = 1'b0;
        repeat (3) @(negedge clk);
        lineE = 1'b1;
        repeat (60) @(negedge clk);
        vectors++;
        if (ifE.fifo_count !== 4'd0 || ifE.data_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL glitch_nopush: got count=%0d valid=%b expected 0/0",
                     ifE.fifo_count, ifE.data_valid);
        end
        sendFrameE(8'hC3, 1'b0, 1'b0, 1'b1);
        while (sbE.size() > 0) begin
            guard = 0;
            while (ifE.data_valid !== 1'b1 && guard < 200) begin
                guard++;
                @(negedge clk);
            end
            exp = sbE.pop_front();
            vectors++;
            if ({ifE.data_valid, ifE.framing_error, ifE.parity_error, ifE.data_out} !== {1'b1, exp}) begin
                miscompares++;
                $display("[TB] FAIL glitch_recover: got %h expected %h",
                         {ifE.data_valid, ifE.framing_error, ifE.parity_error, ifE.data_out}, {1'b1, exp});
            end
            ifE.rd_en = 1'b1;
            @(negedge clk);
            ifE.rd_en = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_tx_even();
        test_loopback_odd();
        test_error_flags();
        test_overflow();
        test_reset_mid_and_glitch();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
